// File: rtl/data_mem.sv
// Word-organised data memory serving one load/store at a time with a fixed access latency,
// byte-enabled writes, and error completion for misaligned or out-of-range addresses.
module data_mem #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    output logic        mem_ready,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned, or any address bit above the word-index field set.
    function automatic logic addr_illegal(input logic [31:0] addr);
        logic [31:0] upper;
        upper = addr >> (ADDR_WIDTH + 2);
        return (addr[1:0] != 2'b00) || (upper != 32'd0);
    endfunction

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic                    write_r;
    logic                    illegal_r;
    logic [ADDR_WIDTH-1:0]   word_r;
    logic [31:0]             wdata_r;
    logic [3:0]              be_r;
    logic                    ready_r;
    logic                    rvalid_r;
    logic [31:0]             rdata_r;
    logic                    err_r;
    logic                    access_s;

    logic [31:0] mem_r [0:(1<<ADDR_WIDTH)-1];

    assign access_s   = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    assign mem_ready  = ready_r;
    assign mem_rvalid = rvalid_r;
    assign mem_rdata  = rdata_r;
    assign mem_err    = err_r;

    // Control FSM: accept, count down the latency, then emit a one-cycle completion.
    // LATENCY=1 still passes through WAIT once so the access always lands on E0+LATENCY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            write_r   <= 1'b0;
            illegal_r <= 1'b0;
            word_r    <= '0;
            wdata_r   <= 32'd0;
            be_r      <= 4'd0;
            ready_r   <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'd0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rvalid_r <= 1'b0;
                    rdata_r  <= 32'd0;
                    err_r    <= 1'b0;
                    if (ready_r && (mem_wen || mem_ren)) begin
                        write_r   <= mem_wen;
                        illegal_r <= addr_illegal(mem_addr);
                        word_r    <= mem_addr[ADDR_WIDTH+1:2];
                        wdata_r   <= mem_wdata;
                        be_r      <= mem_be;
                        cnt_r     <= 4'(LATENCY - 1);
                        ready_r   <= 1'b0;
                        state_r   <= ST_WAIT;
                    end else begin
                        ready_r   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    ready_r <= 1'b0;
                    if (cnt_r == 4'd0) begin
                        rvalid_r <= 1'b1;
                        err_r    <= illegal_r;
                        rdata_r  <= (!write_r && !illegal_r) ? mem_r[word_r] : 32'd0;
                        state_r  <= ST_RESP;
                    end else begin
                        cnt_r    <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    rvalid_r <= 1'b0;
                    rdata_r  <= 32'd0;
                    err_r    <= 1'b0;
                    ready_r  <= 1'b1;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    rvalid_r <= 1'b0;
                    rdata_r  <= 32'd0;
                    err_r    <= 1'b0;
                    ready_r  <= 1'b0;
                    cnt_r    <= 4'd0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage commit: unreset array, byte lanes gated by be; a reset on the access edge discards the write.
    always_ff @(posedge clk) begin
        if (rst && access_s && write_r && !illegal_r) begin
            for (int k = 0; k < 4; k++) begin
                if (be_r[k]) begin
                    mem_r[word_r][8*k +: 8] <= wdata_r[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: instance 0 uses LATENCY=2, instance 1 uses LATENCY=1.
module tb_data_mem;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a    [2];
    logic        ren_a    [2];
    logic        wen_a    [2];
    logic [31:0] addr_a   [2];
    logic [31:0] wdata_a  [2];
    logic [3:0]  be_a     [2];
    logic        ready_a  [2];
    logic        rvalid_a [2];
    logic [31:0] rdata_a  [2];
    logic        err_a    [2];

    int          lat_a [2] = '{2, 1};
    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    logic [31:0] model [int];

    always #5 clk = ~clk;

    data_mem #(.ADDR_WIDTH(10), .LATENCY(2)) u_mem2 (
        .clk(clk), .rst(rst_a[0]), .mem_ren(ren_a[0]), .mem_wen(wen_a[0]),
        .mem_addr(addr_a[0]), .mem_wdata(wdata_a[0]), .mem_be(be_a[0]),
        .mem_ready(ready_a[0]), .mem_rvalid(rvalid_a[0]),
        .mem_rdata(rdata_a[0]), .mem_err(err_a[0])
    );

    data_mem #(.ADDR_WIDTH(10), .LATENCY(1)) u_mem1 (
        .clk(clk), .rst(rst_a[1]), .mem_ren(ren_a[1]), .mem_wen(wen_a[1]),
        .mem_addr(addr_a[1]), .mem_wdata(wdata_a[1]), .mem_be(be_a[1]),
        .mem_ready(ready_a[1]), .mem_rvalid(rvalid_a[1]),
        .mem_rdata(rdata_a[1]), .mem_err(err_a[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Completion monitors: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid_a[0] === 1'b1) begin
            if (exp_q0.size() == 0) begin
                check("spurious_rvalid_l2", 32'd1, 32'd0);
            end else begin
                e = exp_q0.pop_front();
                check("rdata_l2", rdata_a[0], e.rdata);
                check("err_l2", {31'd0, err_a[0]}, {31'd0, e.err});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rvalid_a[1] === 1'b1) begin
            if (exp_q1.size() == 0) begin
                check("spurious_rvalid_l1", 32'd1, 32'd0);
            end else begin
                e = exp_q1.pop_front();
                check("rdata_l1", rdata_a[1], e.rdata);
                check("err_l1", {31'd0, err_a[1]}, {31'd0, e.err});
            end
        end
    end

    task automatic idle_inputs(input int i);
        ren_a[i]   = 1'b0;
        wen_a[i]   = 1'b0;
        addr_a[i]  = 32'd0;
        wdata_a[i] = 32'd0;
        be_a[i]    = 4'd0;
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (ready_a[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", {31'd0, ready_a[i]}, 32'd1);
    endtask

    // Issue one request, record its expected completion, and check latency and ready recovery.
    // With junk set, a conflicting write is held on the bus while the DUT is busy.
    task automatic do_req(input int i, input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b, input bit junk);
        exp_t e;
        bit   legal;
        int   key;
        int   n;
        logic [31:0] cur;
        wait_ready(i);
        wen_a[i] = w; ren_a[i] = r; addr_a[i] = a; wdata_a[i] = d; be_a[i] = b;
        @(posedge clk);
        legal = (a[1:0] == 2'b00) && (a[31:12] == 20'd0);
        key   = i * (1 << 20) + int'(a[11:2]);
        e.err = !legal;
        e.rdata = 32'd0;
        if (w) begin
            if (legal) begin
                cur = model.exists(key) ? model[key] : 32'd0;
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) cur[8*k +: 8] = d[8*k +: 8];
                end
                model[key] = cur;
            end
        end else if (legal) begin
            e.rdata = model.exists(key) ? model[key] : 32'hXXXXXXXX;
        end
        if (i == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        @(negedge clk);
        if (junk) begin
            wen_a[i] = 1'b1; ren_a[i] = 1'b0; addr_a[i] = 32'h8;
            wdata_a[i] = 32'h99; be_a[i] = 4'hF;
        end else begin
            idle_inputs(i);
        end
        n = 1;
        while (rvalid_a[i] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        idle_inputs(i);
        check("latency", n, lat_a[i] + 1);
        check("ready_low_in_resp", {31'd0, ready_a[i]}, 32'd0);
        @(negedge clk);
        check("ready_after_resp", {31'd0, ready_a[i]}, 32'd1);
    endtask

    task automatic reset_mid_write(input int i);
        do_req(i, 1'b1, 1'b0, 32'h20, 32'h12345678, 4'hF, 1'b0);
        wait_ready(i);
        wen_a[i] = 1'b1; addr_a[i] = 32'h20; wdata_a[i] = 32'h77; be_a[i] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        idle_inputs(i);
        rst_a[i] = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, ready_a[i]}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid_a[i]}, 32'd0);
        check("rst_err", {31'd0, err_a[i]}, 32'd0);
        check("rst_rdata", rdata_a[i], 32'd0);
        rst_a[i] = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, ready_a[i]}, 32'd1);
        do_req(i, 1'b0, 1'b1, 32'h20, 32'd0, 4'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_a[i] = 1'b0;
            idle_inputs(i);
        end
        // Requests presented during reset must be dropped.
        wen_a[0] = 1'b1; addr_a[0] = 32'h8; wdata_a[0] = 32'h33; be_a[0] = 4'hF;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_ready", {31'd0, ready_a[i]}, 32'd0);
            check("reset_rvalid", {31'd0, rvalid_a[i]}, 32'd0);
            check("reset_err", {31'd0, err_a[i]}, 32'd0);
            check("reset_rdata", rdata_a[i], 32'd0);
        end
        idle_inputs(0);
        rst_a[0] = 1'b1;
        rst_a[1] = 1'b1;
        @(negedge clk);
        check("ready_first_edge", {31'd0, ready_a[0]}, 32'd1);

        do_req(0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h40, 32'd0, 4'h0, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h11223344, 4'hF, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'hAABBCCDD, 4'b0101, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'd0, 4'hF, 1'b0);
        do_req(0, 1'b1, 1'b1, 32'h8, 32'h5, 4'hF, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h40, 32'd0, 4'h0, 1'b1);
        do_req(0, 1'b0, 1'b1, 32'h8, 32'd0, 4'h0, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'd0, 4'h0, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h42, 32'd0, 4'h0, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h1000, 32'h0BADF00D, 4'hF, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h2, 32'h0BADF00D, 4'hF, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h0, 32'd0, 4'h0, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'hFFC, 32'd0, 4'h0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            logic [31:0] a;
            a = {20'd0, 10'($urandom_range(64, 1023)), 2'b00};
            do_req(0, 1'b1, 1'b0, a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
            do_req(0, 1'b0, 1'b1, a, 32'd0, 4'h0, 1'b0);
        end

        reset_mid_write(0);
        reset_mid_write(1);
        do_req(1, 1'b1, 1'b0, 32'h44, 32'hA5A5A5A5, 4'b1001, 1'b0);
        do_req(1, 1'b0, 1'b1, 32'h44, 32'd0, 4'h0, 1'b0);

        repeat (5) @(negedge clk);
        check("queue_empty_l2", exp_q0.size(), 32'd0);
        check("queue_empty_l1", exp_q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
